// File: rtl/event_indicator_pkg.sv
// Shared definitions for the event indicator: FSM encoding, default time base
// and a width helper. The default TICK_DIV is also used by the button debouncer.
package event_indicator_pkg;

  localparam logic [1:0] IDLE_ENC = 2'd0;
  localparam logic [1:0] ON_ENC   = 2'd1;
  localparam logic [1:0] GAP_ENC  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE_ENC,
    ST_ON   = ON_ENC,
    ST_GAP  = GAP_ENC
  } ind_state_e;

  localparam int DEFAULT_TICK_DIV = 100;

  function automatic int pend_width(input int pend_max);
    return $clog2(pend_max + 1);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/event_indicator_if.sv
// Event strobe in, indicator status out; master = pulse source, slave = indicator.
interface event_indicator_if #(
  parameter int PEND_MAX = 15
);
  import event_indicator_pkg::*;

  localparam int PW = pend_width(PEND_MAX);

  logic          i_pulse;
  logic          o_ind;
  logic          o_busy;
  logic [PW-1:0] o_pending;
  logic          o_drop;

  modport master (output i_pulse, input o_ind, input o_busy, input o_pending, input o_drop);
  modport slave  (input i_pulse, output o_ind, output o_busy, output o_pending, output o_drop);

endinterface

// File: rtl/event_indicator_tick_prescaler.sv
// Free-running 0..TICK_DIV-1 counter with a tick strobe on the last count and a
// synchronous clear that restarts the phase; reusable by the debouncer.
module tick_prescaler
  import event_indicator_pkg::*;
#(
  parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int            CW   = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // next count: clear wins over counting
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // count register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/event_indicator.sv
// Stretches single-cycle event strobes into fixed-length indicator pulses, queueing
// events that arrive while busy. Define EVENT_INDICATOR_RETRIGGER_EN to restart ON instead.
module event_indicator
  import event_indicator_pkg::*;
#(
  parameter int TICK_DIV  = DEFAULT_TICK_DIV,
  parameter int ON_TICKS  = 50,
  parameter int GAP_TICKS = 25,
  parameter int PEND_MAX  = 15
) (
  input  logic               clk,
  input  logic               rst,
  event_indicator_if.slave   bus
);

  localparam int            PW       = pend_width(PEND_MAX);
  localparam int            TW       = $clog2(max_int(ON_TICKS, GAP_TICKS) + 1);
  localparam logic [TW-1:0] ON_LAST  = TW'(ON_TICKS - 1);
  localparam logic [TW-1:0] GAP_LAST = TW'((GAP_TICKS > 0) ? (GAP_TICKS - 1) : 0);
  localparam logic [PW-1:0] PEND_TOP = PW'(PEND_MAX);

  ind_state_e    state_q, state_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [PW-1:0] pending_q, pending_d;
  logic          ind_q, busy_q, drop_q, drop_d;
  logic          tick_s, clr_s, resolve_s, queue_s;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .en_i   (state_q != ST_IDLE),
    .clr_i  (clr_s),
    .tick_o (tick_s)
  );

  // phase sequencing, queue bookkeeping and the end-of-gap decision
  always_comb begin
    state_d   = state_q;
    tcnt_d    = tcnt_q;
    pending_d = pending_q;
    drop_d    = 1'b0;
    clr_s     = 1'b0;
    resolve_s = 1'b0;
    queue_s   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.i_pulse) begin
          state_d = ST_ON;
          tcnt_d  = '0;
          clr_s   = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ON: begin
        if (tick_s) begin
          if (tcnt_q == ON_LAST) begin
            tcnt_d = '0;
            clr_s  = 1'b1;
            // with no gap the end of ON is itself the replay decision point
            if (GAP_TICKS == 0) begin
              resolve_s = 1'b1;
            end else begin
              state_d = ST_GAP;
            end
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end else begin
          tcnt_d = tcnt_q;
        end
`ifdef EVENT_INDICATOR_RETRIGGER_EN
        if (bus.i_pulse) begin
          state_d   = ST_ON;
          tcnt_d    = '0;
          clr_s     = 1'b1;
          resolve_s = 1'b0;
        end else begin
          queue_s = 1'b0;
        end
`else
        queue_s = bus.i_pulse && !resolve_s;
`endif
      end
      ST_GAP: begin
        if (tick_s) begin
          if (tcnt_q == GAP_LAST) begin
            tcnt_d    = '0;
            clr_s     = 1'b1;
            resolve_s = 1'b1;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end else begin
          tcnt_d = tcnt_q;
        end
        queue_s = bus.i_pulse && !resolve_s;
      end
      default: begin
        state_d = ST_IDLE;
        tcnt_d  = '0;
      end
    endcase

    // a pulse on the decision cycle is either absorbed or cancels the decrement
    if (resolve_s) begin
      if (pending_q != '0) begin
        state_d = ST_ON;
        if (!bus.i_pulse) begin
          pending_d = pending_q - 1'b1;
        end else begin
          pending_d = pending_q;
        end
      end else if (bus.i_pulse) begin
        state_d = ST_ON;
      end else begin
        state_d = ST_IDLE;
      end
    end else begin
      pending_d = pending_q;
    end

    if (queue_s) begin
      if (pending_q < PEND_TOP) begin
        pending_d = pending_q + 1'b1;
      end else begin
        drop_d = 1'b1;
      end
    end else begin
      drop_d = 1'b0;
    end
  end

  // state, counters and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      tcnt_q    <= '0;
      pending_q <= '0;
      ind_q     <= 1'b0;
      busy_q    <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tcnt_q    <= tcnt_d;
      pending_q <= pending_d;
      ind_q     <= (state_q == ST_ON);
      busy_q    <= (state_q != ST_IDLE);
      drop_q    <= drop_d;
    end
  end

  assign bus.o_ind     = ind_q;
  assign bus.o_busy    = busy_q;
  assign bus.o_pending = pending_q;
  assign bus.o_drop    = drop_q;

endmodule

// File: tb/tb_event_indicator.sv
// Directed bench for event_indicator with TICK_DIV=4, ON_TICKS=2, GAP_TICKS=1, PEND_MAX=3.
module tb_event_indicator;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_total = 0;
  int   n_pass  = 0;

  event_indicator_if #(.PEND_MAX(3)) bus ();

  event_indicator #(
    .TICK_DIV(4), .ON_TICKS(2), .GAP_TICKS(1), .PEND_MAX(3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    for (int n = 0; n < 200; n++) begin
      if (!bus.o_busy) break;
      step();
    end
    check(tag, {31'd0, bus.o_busy}, 32'd0);
  endtask

  initial begin
    bus.i_pulse = 1'b0;
    step();
    step();
    check("rst_ind",  {31'd0, bus.o_ind},  32'd0);
    check("rst_busy", {31'd0, bus.o_busy}, 32'd0);
    check("rst_pend", {30'd0, bus.o_pending}, 32'd0);
    check("rst_drop", {31'd0, bus.o_drop}, 32'd0);
    #2 rst = 1'b1;
    step();

    // single pulse: ON after edges 1..8, GAP 9..12, idle at 13
    for (int k = 0; k <= 13; k++) begin
      bus.i_pulse = (k == 0);
      step();
      check($sformatf("t1_ind[%0d]", k),  {31'd0, bus.o_ind},  {31'd0, (k >= 1 && k <= 8)});
      check($sformatf("t1_busy[%0d]", k), {31'd0, bus.o_busy}, {31'd0, (k >= 1 && k <= 12)});
      check($sformatf("t1_pend[%0d]", k), {30'd0, bus.o_pending}, 32'd0);
    end

    // three queued pulses: four ON windows with 4-cycle gaps, pending 3,2,1,0
    for (int k = 0; k <= 50; k++) begin
      bus.i_pulse = (k <= 3);
      step();
      check($sformatf("t2_ind[%0d]", k), {31'd0, bus.o_ind},
            {31'd0, (k >= 1 && k <= 48 && ((k - 1) % 12) < 8)});
      check($sformatf("t2_busy[%0d]", k), {31'd0, bus.o_busy}, {31'd0, (k >= 1 && k <= 48)});
      check($sformatf("t2_pend[%0d]", k), {30'd0, bus.o_pending},
            (k <= 3) ? k : (k < 12) ? 32'd3 : (k < 24) ? 32'd2 : (k < 36) ? 32'd1 : 32'd0);
      check($sformatf("t2_drop[%0d]", k), {31'd0, bus.o_drop}, 32'd0);
    end

    // five pulses during ON: saturate at 3, drop for the 4th and 5th
    for (int k = 0; k <= 6; k++) begin
      bus.i_pulse = (k <= 5);
      step();
      check($sformatf("t3_pend[%0d]", k), {30'd0, bus.o_pending}, (k <= 3) ? k : 32'd3);
      check($sformatf("t3_drop[%0d]", k), {31'd0, bus.o_drop}, {31'd0, (k == 4 || k == 5)});
    end
    bus.i_pulse = 1'b0;
    wait_idle("t3_idle");

    // pulse on the GAP-end cycle with nothing pending: re-enter ON, pending stays 0
    for (int k = 0; k <= 26; k++) begin
      bus.i_pulse = (k == 0 || k == 12);
      step();
      check($sformatf("t4_ind[%0d]", k), {31'd0, bus.o_ind},
            {31'd0, ((k >= 1 && k <= 8) || (k >= 13 && k <= 20))});
      check($sformatf("t4_busy[%0d]", k), {31'd0, bus.o_busy}, {31'd0, (k >= 1 && k <= 24)});
      check($sformatf("t4_pend[%0d]", k), {30'd0, bus.o_pending}, 32'd0);
    end

    // pulse on the GAP-end cycle with pending=2: pending unchanged, ON re-entered
    for (int k = 0; k <= 15; k++) begin
      bus.i_pulse = (k <= 2 || k == 12);
      step();
      check($sformatf("t5_pend[%0d]", k), {30'd0, bus.o_pending}, (k <= 2) ? k : 32'd2);
      check($sformatf("t5_ind[%0d]", k), {31'd0, bus.o_ind},
            {31'd0, ((k >= 1 && k <= 8) || k >= 13)});
    end
    bus.i_pulse = 1'b0;

    // asynchronous reset mid-ON discards everything without a clock edge
    #2 rst = 1'b0;
    #1;
    check("t6_rst_ind",  {31'd0, bus.o_ind},  32'd0);
    check("t6_rst_busy", {31'd0, bus.o_busy}, 32'd0);
    check("t6_rst_pend", {30'd0, bus.o_pending}, 32'd0);
    step();
    #2 rst = 1'b1;
    step();
    for (int k = 0; k <= 9; k++) begin
      bus.i_pulse = (k == 0);
      step();
      check($sformatf("t6_ind[%0d]", k), {31'd0, bus.o_ind}, {31'd0, (k >= 1 && k <= 8)});
      check($sformatf("t6_pend[%0d]", k), {30'd0, bus.o_pending}, 32'd0);
    end
    wait_idle("t6_idle");

`ifdef EVENT_INDICATOR_RETRIGGER_EN
    // pulse 5 cycles into ON restarts the 8-cycle window
    for (int k = 0; k <= 18; k++) begin
      bus.i_pulse = (k == 0 || k == 5);
      step();
      check($sformatf("t7_ind[%0d]", k), {31'd0, bus.o_ind}, {31'd0, (k >= 1 && k <= 13)});
      check($sformatf("t7_pend[%0d]", k), {30'd0, bus.o_pending}, 32'd0);
    end
`else
    // same stimulus queues instead of extending
    for (int k = 0; k <= 9; k++) begin
      bus.i_pulse = (k == 0 || k == 5);
      step();
      check($sformatf("t7_ind[%0d]", k), {31'd0, bus.o_ind}, {31'd0, (k >= 1 && k <= 8)});
      check($sformatf("t7_pend[%0d]", k), {30'd0, bus.o_pending}, (k >= 5) ? 32'd1 : 32'd0);
    end
`endif
    bus.i_pulse = 1'b0;
    wait_idle("t7_idle");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
